// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: arbiter state encoding and port index width.
package rv32i_types;

    localparam int unsigned PORT_IDX_W = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way request picker: round-robin on ties, or port 0 always wins when fixed is set.
module rr_pick
    import rv32i_types::*;
(
    input  logic [1:0]            req,
    input  logic [PORT_IDX_W-1:0] last,
    input  logic                  fixed,
    output logic [1:0]            pick
);

    always_comb begin
        pick = 2'b00;
        unique case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            // On a tie, serve the port that did not go last.
            2'b11:   pick = (fixed || last == 1'b1) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter; one access outstanding at a time, no preemption.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] p0_addr,
    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [3:0]  p0_wmask,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_resp,

    input  logic [31:0] p1_addr,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [3:0]  p1_wmask,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_resp,

    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    output logic [1:0]  gnt
);

    mem_arb_state_t        state_q, state_d;
    logic [PORT_IDX_W-1:0] last_q, last_d;
    logic [1:0]            req;
    logic [1:0]            pick;

    assign req = {p1_read | p1_write, p0_read | p0_write};

    rr_pick u_rr_pick (
        .req   (req),
        .last  (last_q),
        .fixed (PRIO_FIXED != 0),
        .pick  (pick)
    );

    assign p0_rdata = mem_rdata;
    assign p1_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        mem_addr  = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wmask = 4'h0;
        mem_wdata = 32'h0;
        p0_resp   = 1'b0;
        p1_resp   = 1'b0;
        gnt       = 2'b00;

        // Outputs are held quiet while rst is high so an in-flight access is dropped at once.
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pick[0]) begin
                        state_d = S_GNT0;
                    end else if (pick[1]) begin
                        state_d = S_GNT1;
                    end
                end
                S_GNT0: begin
                    gnt       = 2'b01;
                    mem_addr  = p0_addr;
                    mem_read  = p0_read;
                    mem_write = p0_write;
                    mem_wmask = p0_wmask;
                    mem_wdata = p0_wdata;
                    if (!req[0]) begin
                        state_d = S_IDLE;
                    end else if (mem_resp) begin
                        p0_resp = 1'b1;
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_GNT1: begin
                    gnt       = 2'b10;
                    mem_addr  = p1_addr;
                    mem_read  = p1_read;
                    mem_write = p1_write;
                    mem_wmask = p1_wmask;
                    mem_wdata = p1_wdata;
                    if (!req[1]) begin
                        state_d = S_IDLE;
                    end else if (mem_resp) begin
                        p1_resp = 1'b1;
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance plus a fixed-priority twin on shared inputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [3:0]  p0_wmask, p1_wmask;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic        p0_resp, p1_resp, mem_read, mem_write;
    logic [3:0]  mem_wmask;
    logic [1:0]  gnt;

    logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;
    logic        f_p0_resp, f_p1_resp, f_mem_read, f_mem_write;
    logic [3:0]  f_mem_wmask;
    logic [1:0]  f_gnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.PRIO_FIXED(0)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_read(p0_read), .p0_write(p0_write), .p0_wmask(p0_wmask),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_resp(p0_resp),
        .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write), .p1_wmask(p1_wmask),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_resp(p1_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .gnt(gnt)
    );

    mem_arbiter #(.PRIO_FIXED(1)) dut_fix (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_read(p0_read), .p0_write(p0_write), .p0_wmask(p0_wmask),
        .p0_wdata(p0_wdata), .p0_rdata(f_p0_rdata), .p0_resp(f_p0_resp),
        .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write), .p1_wmask(p1_wmask),
        .p1_wdata(p1_wdata), .p1_rdata(f_p1_rdata), .p1_resp(f_p1_resp),
        .mem_addr(f_mem_addr), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_wmask(f_mem_wmask), .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .gnt(f_gnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        p0_addr = '0; p0_read = 0; p0_write = 0; p0_wmask = '0; p0_wdata = '0;
        p1_addr = '0; p1_read = 0; p1_write = 0; p1_wmask = '0; p1_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        nxt();
        nxt();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        nxt();
        settle();
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_resp", {p0_resp, p1_resp}, 2'b00);
        nxt();
        rst = 0;
        settle();
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_mem_addr", mem_addr, 32'h0);

        // Single requester, memory answers on cycle 4.
        p0_read = 1; p0_addr = 32'h4000_0000;
        settle();
        check_eq("s1_c0_gnt", gnt, 2'b00);
        check_eq("s1_c0_mem_read", mem_read, 1'b0);
        nxt(); settle();
        check_eq("s1_c1_gnt", gnt, 2'b01);
        check_eq("s1_c1_mem_read", mem_read, 1'b1);
        check_eq("s1_c1_mem_addr", mem_addr, 32'h4000_0000);
        nxt(); nxt(); settle();
        check_eq("s1_c3_wait_gnt", gnt, 2'b01);
        check_eq("s1_c3_no_resp", p0_resp, 1'b0);
        nxt();
        mem_resp = 1; mem_rdata = 32'h0000_0013;
        settle();
        check_eq("s1_c4_p0_resp", p0_resp, 1'b1);
        check_eq("s1_c4_p0_rdata", p0_rdata, 32'h0000_0013);
        check_eq("s1_c4_p1_resp", p1_resp, 1'b0);
        nxt();
        p0_read = 0; mem_resp = 0;
        settle();
        check_eq("s1_c5_gnt", gnt, 2'b00);
        check_eq("s1_c5_p0_resp", p0_resp, 1'b0);

        // Tie after reset: port 0 first, then port 1 write.
        do_reset();
        p0_read = 1; p0_addr = 32'h4000_0000;
        p1_write = 1; p1_addr = 32'h0000_1000; p1_wmask = 4'hF; p1_wdata = 32'hDEAD_BEEF;
        settle();
        check_eq("s2_c0_gnt", gnt, 2'b00);
        nxt();
        mem_resp = 1;
        settle();
        check_eq("s2_c1_gnt", gnt, 2'b01);
        check_eq("s2_c1_mem_addr", mem_addr, 32'h4000_0000);
        check_eq("s2_c1_rw", {mem_read, mem_write}, 2'b10);
        check_eq("s2_c1_resp", {p1_resp, p0_resp}, 2'b01);
        nxt();
        p0_read = 0; mem_resp = 0;
        settle();
        check_eq("s2_c2_gnt", gnt, 2'b00);
        nxt();
        mem_resp = 1;
        settle();
        check_eq("s2_c3_gnt", gnt, 2'b10);
        check_eq("s2_c3_rw", {mem_read, mem_write}, 2'b01);
        check_eq("s2_c3_mem_addr", mem_addr, 32'h0000_1000);
        check_eq("s2_c3_wmask", mem_wmask, 4'hF);
        check_eq("s2_c3_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("s2_c3_resp", {p1_resp, p0_resp}, 2'b10);
        nxt();
        p1_write = 0; mem_resp = 0;
        settle();
        check_eq("s2_c4_gnt", gnt, 2'b00);

        // Fairness: both ports request continuously, memory always ready.
        do_reset();
        p0_read = 1; p0_addr = 32'h100;
        p1_read = 1; p1_addr = 32'h200;
        mem_resp = 1;
        for (int i = 0; i < 8; i++) begin
            settle();
            check_eq($sformatf("s3_idle%0d", i), gnt, 2'b00);
            nxt(); settle();
            check_eq($sformatf("s3_rr%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            check_eq($sformatf("s3_fix%0d", i), f_gnt, 2'b01);
            nxt();
        end

        // Abort by port 1 with port 0 waiting.
        do_reset();
        p1_read = 1; p1_addr = 32'h300;
        nxt(); settle();
        check_eq("s4_c1_gnt", gnt, 2'b10);
        p0_read = 1; p0_addr = 32'h400;
        nxt();
        p1_read = 0;
        settle();
        check_eq("s4_c2_gnt", gnt, 2'b10);
        check_eq("s4_c2_p1_resp", p1_resp, 1'b0);
        nxt(); settle();
        check_eq("s4_c3_gnt", gnt, 2'b00);
        nxt(); settle();
        check_eq("s4_c4_gnt", gnt, 2'b01);
        check_eq("s4_c4_mem_addr", mem_addr, 32'h400);
        // Read and write together are forwarded as-is.
        p0_write = 1;
        settle();
        check_eq("s4_rw_both", {mem_read, mem_write}, 2'b11);
        mem_resp = 1;
        settle();
        check_eq("s4_c4_resp", {p1_resp, p0_resp}, 2'b01);
        nxt();
        p0_read = 0; p0_write = 0; mem_resp = 0;

        // Reset mid-access, then a late response.
        do_reset();
        p0_read = 1; p0_addr = 32'h500;
        nxt(); settle();
        check_eq("s5_c1_mem_read", mem_read, 1'b1);
        nxt();
        rst = 1;
        nxt();
        rst = 0; p0_read = 0; mem_resp = 1;
        settle();
        check_eq("s5_after_gnt", gnt, 2'b00);
        check_eq("s5_after_mem_read", mem_read, 1'b0);
        check_eq("s5_late_resp", {p1_resp, p0_resp}, 2'b00);

        // Stray response while idle.
        nxt(); settle();
        check_eq("s6_stray_resp", {p1_resp, p0_resp}, 2'b00);
        nxt(); settle();
        check_eq("s6_stray_gnt", gnt, 2'b00);
        mem_resp = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
